full_subtractor_pipe: RTL and testbench
=======================================

// Module: full_subtractor_pipe
// PURPOSE
//   Registered ripple-borrow full subtractor: diff = a - b - bin, with borrow-out.
//   Generalises the 1-bit full-subtractor cell to WIDTH bits; stage boundary on outputs.
//   Used as arithmetic leaf in datapaths and as the gate-level reference cell in unit benches.
// PARAMETERS
//   WIDTH  1  operand width in bits (>=1); WIDTH=1 is the classic full-subtractor cell
// PORTS
//   clk        in   1      single clock, rising-edge
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      operands valid this cycle
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      registered result valid
//   diff       out  WIDTH  registered difference
//   bout       out  1      registered borrow-out
//   zero       out  1      diff==0 (only with FSUB_FLAGS_EN)
//   ovf        out  1      signed overflow (only with FSUB_FLAGS_EN)
// BEHAVIOUR
//   - One clock; reset asynchronous, active-low (rst_n); all flops use it.
//   - Per bit i, borrow chain br[0]=bin:
//       d[i]    = a[i] ^ b[i] ^ br[i]
//       br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i])
//     bout_next = br[WIDTH]; result satisfies {~bout? 0:1, diff} == a - b - bin mod 2^(WIDTH+1).
//   - Unsigned wrap: a - b - bin < 0 -> diff = 2^WIDTH + (a - b - bin), bout=1.
//   - Latency 1 cycle: in_valid=1 at edge N -> diff/bout/out_valid at edge N updated.
//   - in_valid=0 at edge: out_valid<=0; diff/bout HOLD previous values (no toggling).
//   - No backpressure; every valid input yields exactly one valid output next cycle.
//   - Reset (assert any time, incl. mid-stream): out_valid=0, diff=0, bout=0
//     (and zero=0, ovf=0) immediately, independent of clk; first valid result
//     appears 1 cycle after the first in_valid=1 edge following deassertion.
//   - X/unknown on a/b/bin while in_valid=0 must not propagate to outputs.
// CONFIGURATION
//   FSUB_FLAGS_EN defined: zero and ovf ports present, registered with diff:
//     zero = (d_next == 0); ovf = (a[MSB] != b[MSB]) && (d_next[MSB] != a[MSB])
//     (signed view of a - b - bin); held when in_valid=0; reset to 0.
//   FSUB_FLAGS_EN undefined: zero/ovf ports absent; all other behaviour identical.
// TESTING
//   WIDTH=1 exhaustive 8 combos (a,b,bin): 000->d0 b0; 001->d1 b1; 100->d1 b0;
//     101->d0 b0; 010->d1 b1; 011->d0 b1; 110->d0 b0; 111->d1 b1 (1 cycle later).
//   WIDTH=8 a=0x00,b=0xFF,bin=1 -> diff=0x00, bout=1; a=0x50,b=0x20,bin=0 -> 0x30, bout=0.
//   Valid gating: pulse in_valid 1 cycle then hold 0 with random a/b -> out_valid one
//     cycle high, diff/bout frozen afterwards.
//   Reset mid-stream: rst_n low between edges -> outputs 0 immediately; resume after release.
//   FSUB_FLAGS_EN WIDTH=8: a=0x80,b=0x01,bin=0 -> diff=0x7F, ovf=1, zero=0;
//     a=0x05,b=0x04,bin=1 -> diff=0x00, zero=1.
//   Random WIDTH=16 back-to-back stream vs. a - b - bin reference model, 10k vectors.

Source files
------------

// File: rtl/full_subtractor_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor_pipe
//  Purpose  : Registered ripple-borrow full subtractor, diff = a - b - bin,
//             with borrow-out. WIDTH=1 is the classic full-subtractor cell.
//             Results are registered; data outputs hold while in_valid=0.
//  Options  : FSUB_FLAGS_EN - adds registered zero / signed-overflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module full_subtractor_pipe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
`ifdef FSUB_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int c_MSB = WIDTH - 1;

    // Borrow chain: w_br[0] is the borrow-in, w_br[WIDTH] the borrow-out.
    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_diff;

    assign w_br[0] = bin;

    // One full-subtractor cell per bit, rippling the borrow upward.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign w_diff[i]  = a[i] ^ b[i] ^ w_br[i];
            assign w_br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_br[i]);
        end
    endgenerate

    logic             valid_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             bout_q;
    logic             bout_d;

    // Next-state for the data registers: load on valid, otherwise hold so that
    // unknown operands presented while idle never reach the outputs.
    always_comb begin
        diff_d = diff_q;
        bout_d = bout_q;
        if (in_valid) begin
            diff_d = w_diff;
            bout_d = w_br[WIDTH];
        end
    end

    // Output stage: valid tracks in_valid one cycle later, data loads or holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign out_valid = valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

`ifdef FSUB_FLAGS_EN
    logic zero_q;
    logic zero_d;
    logic ovf_q;
    logic ovf_d;

    // Flags follow the same load/hold rule as diff. Overflow uses the signed
    // view: operands of differing sign whose result sign departs from a.
    always_comb begin
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (in_valid) begin
            zero_d = (w_diff == '0);
            ovf_d  = (a[c_MSB] != b[c_MSB]) && (w_diff[c_MSB] != a[c_MSB]);
        end
    end

    // Flag registers, reset together with the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_subtractor_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_full_subtractor_pipe
//  Purpose  : Directed and reference-model checks of full_subtractor_pipe at
//             WIDTH = 1, 8 and 16. Flag checks are compiled with FSUB_FLAGS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_full_subtractor_pipe;

    logic clk;
    logic rst_n;

    // WIDTH=1 instance signals
    logic       v1_i, a1, b1, bin1;
    logic       ov1, d1, bo1;
    // WIDTH=8 instance signals
    logic       v8_i, bin8;
    logic [7:0] a8, b8, d8;
    logic       ov8, bo8;
    // WIDTH=16 instance signals
    logic        v16_i, bin16;
    logic [15:0] a16, b16, d16;
    logic        ov16, bo16;
`ifdef FSUB_FLAGS_EN
    logic z1, o1, z8, o8, z16, o16;
`endif

    int n_vec;
    int n_err;

    full_subtractor_pipe #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_i), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .diff(d1),
`ifdef FSUB_FLAGS_EN
        .zero(z1), .ovf(o1),
`endif
        .bout(bo1));

    full_subtractor_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8_i), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .diff(d8),
`ifdef FSUB_FLAGS_EN
        .zero(z8), .ovf(o8),
`endif
        .bout(bo8));

    full_subtractor_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16_i), .a(a16), .b(b16), .bin(bin16),
        .out_valid(ov16), .diff(d16),
`ifdef FSUB_FLAGS_EN
        .zero(z16), .ovf(o16),
`endif
        .bout(bo16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one WIDTH=8 vector at the falling edge, sample 1 ns after the rise.
    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic v);
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; v8_i = v;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  exp1_d;
    logic [7:0]  exp1_b;
    logic [2:0]  idx;
    logic [16:0] ref16;
    logic [7:0]  held_d;
    logic        held_b;

    initial begin
        n_vec = 0;
        n_err = 0;
        v1_i = 0; a1 = 0; b1 = 0; bin1 = 0;
        v8_i = 0; a8 = 0; b8 = 0; bin8 = 0;
        v16_i = 0; a16 = 0; b16 = 0; bin16 = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid8", {31'd0, ov8}, 32'd0);
        check("rst_diff8",  {24'd0, d8},  32'd0);
        check("rst_bout8",  {31'd0, bo8}, 32'd0);
        check("rst_valid1", {31'd0, ov1}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive: expected d/bout indexed by {a,b,bin}.
        exp1_d = 8'b1001_0110;
        exp1_b = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            @(negedge clk);
            {a1, b1, bin1} = idx;
            v1_i = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("w1_valid_%0d", i), {31'd0, ov1}, 32'd1);
            check($sformatf("w1_diff_%0d", i),  {31'd0, d1},  {31'd0, exp1_d[idx]});
            check($sformatf("w1_bout_%0d", i),  {31'd0, bo1}, {31'd0, exp1_b[idx]});
        end
        @(negedge clk);
        v1_i = 1'b0;

        // WIDTH=8 directed boundary vectors.
        step8(8'h00, 8'hFF, 1'b1, 1'b1);
        check("w8_wrap_diff", {24'd0, d8},  32'h00);
        check("w8_wrap_bout", {31'd0, bo8}, 32'd1);
        check("w8_wrap_vld",  {31'd0, ov8}, 32'd1);
        step8(8'h50, 8'h20, 1'b0, 1'b1);
        check("w8_sub_diff", {24'd0, d8},  32'h30);
        check("w8_sub_bout", {31'd0, bo8}, 32'd0);
        check("w8_sub_vld",  {31'd0, ov8}, 32'd1);

        // Valid gating: idle cycles with changing operands must freeze outputs.
        for (int i = 0; i < 4; i++) begin
            step8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            check("gate_vld",  {31'd0, ov8}, 32'd0);
            check("gate_diff", {24'd0, d8},  32'h30);
            check("gate_bout", {31'd0, bo8}, 32'd0);
        end

`ifdef FSUB_FLAGS_EN
        step8(8'h80, 8'h01, 1'b0, 1'b1);
        check("flg_ovf_diff", {24'd0, d8},  32'h7F);
        check("flg_ovf_ovf",  {31'd0, o8},  32'd1);
        check("flg_ovf_zero", {31'd0, z8},  32'd0);
        step8(8'h05, 8'h04, 1'b1, 1'b1);
        check("flg_z_diff", {24'd0, d8}, 32'h00);
        check("flg_z_zero", {31'd0, z8}, 32'd1);
        check("flg_z_ovf",  {31'd0, o8}, 32'd0);
        step8(8'h11, 8'h22, 1'b0, 1'b0);
        check("flg_hold_zero", {31'd0, z8}, 32'd1);
`endif

        // Mid-stream reset: outputs clear between edges without a clock.
        step8(8'h10, 8'h01, 1'b0, 1'b1);
        check("pre_rst_diff", {24'd0, d8}, 32'h0F);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld",  {31'd0, ov8}, 32'd0);
        check("mid_rst_diff", {24'd0, d8},  32'd0);
        check("mid_rst_bout", {31'd0, bo8}, 32'd0);
`ifdef FSUB_FLAGS_EN
        check("mid_rst_zero", {31'd0, z8}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step8(8'h03, 8'h07, 1'b0, 1'b0);
        check("post_rst_idle", {31'd0, ov8}, 32'd0);
        step8(8'h03, 8'h07, 1'b0, 1'b1);
        check("post_rst_diff", {24'd0, d8},  32'hFC);
        check("post_rst_bout", {31'd0, bo8}, 32'd1);
        step8(8'h00, 8'h00, 1'b0, 1'b0);
        held_d = d8;
        held_b = bo8;
        check("post_rst_drop", {31'd0, ov8}, 32'd0);

        // WIDTH=16 back-to-back random stream against arithmetic reference.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            bin16 = 1'($urandom);
            v16_i = 1'b1;
            ref16 = {1'b0, a16} - {1'b0, b16} - {16'd0, bin16};
            @(posedge clk);
            #1;
            check("w16_vld",  {31'd0, ov16}, 32'd1);
            check("w16_diff", {16'd0, d16},  {16'd0, ref16[15:0]});
            check("w16_bout", {31'd0, bo16}, {31'd0, ref16[16]});
        end
        @(negedge clk);
        v16_i = 1'b0;
        @(posedge clk);
        #1;
        check("w16_end_vld", {31'd0, ov16}, 32'd0);
        check("w8_still_held", {23'd0, bo8, d8}, {23'd0, held_b, held_d});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
